// File: rtl/decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_ctrl
//  Description : IF->ID pipeline boundary controller for the 16-bit core.
//                Holds the decode instruction, handshakes with fetch and
//                execute, inserts load-use bubbles, flushes on taken
//                branches and counts hazard-stall cycles (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  output logic             if_ready,
  output logic             id_valid,
  output logic [15:0]      id_instr,
  input  logic             id_ready,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [3:0]       ex_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FULL   = 2'd1;
  localparam logic [1:0] ST_HAZARD = 2'd2;

  localparam logic [3:0] C_STALL_INIT = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] C_OP_NOREG   = 4'b0111;

  logic [1:0]       state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [3:0] w_op;
  logic       w_reads_a;
  logic       w_reads_b;
  logic       w_hazard;
  logic       w_full;
  logic       w_capture;
  logic       w_handoff;

  // Decode which source registers the held instruction reads and detect load-use
  always_comb begin
    w_op      = instr_q[15:12];
    w_reads_a = (w_op != C_OP_NOREG);
    w_reads_b = w_op[3];
    w_full    = (state_q == ST_FULL);
    w_hazard  = w_full & ex_valid & ex_is_load &
                ((w_reads_a & (ex_rd == instr_q[11:8])) |
                 (w_reads_b & (ex_rd == instr_q[7:4])));
    id_valid  = w_full & ~w_hazard;
    if_ready  = ~flush & ((state_q == ST_EMPTY) | (w_full & id_ready & ~w_hazard));
    w_capture = if_valid & if_ready;
    w_handoff = id_valid & id_ready;
  end

  // Next-state, instruction register, bubble counter and stall counter updates
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (flush) begin
      // Flush wins in every state; a coincident hand-off is squashed by EX
      state_d = ST_EMPTY;
      instr_d = 16'h0000;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_capture) begin
            state_d = ST_FULL;
            instr_d = if_instr;
          end
        end
        ST_FULL: begin
          if (w_hazard) begin
            state_d = ST_HAZARD;
            cnt_d   = C_STALL_INIT;
          end else if (w_handoff && w_capture) begin
            instr_d = if_instr;
          end else if (w_handoff) begin
            state_d = ST_EMPTY;
          end
        end
        ST_HAZARD: begin
          if (stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
          end
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            // Return to FULL, where the hazard is evaluated again
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Register update with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= 16'h0000;
      cnt_q   <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign id_instr    = instr_q;
  assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_ctrl
//  Description : Directed self-checking bench for decode_stage_ctrl. A second
//                instance (CNT_W=4, STALL_CYCLES=2) covers saturation and
//                flush during a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        id_ready;
  logic        ex_valid;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic        flush;

  logic        if_ready, id_valid;
  logic [15:0] id_instr;
  logic [15:0] stall_count;

  logic        s_if_ready, s_id_valid;
  logic [15:0] s_id_instr;
  logic [3:0]  s_stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  decode_stage_ctrl u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .flush(flush), .stall_count(stall_count)
  );

  decode_stage_ctrl #(.STALL_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(s_if_ready), .id_valid(s_id_valid), .id_instr(s_id_instr),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .flush(flush), .stall_count(s_stall_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0; id_ready = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 4'h0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %b exp 0", id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready got %b exp 1", if_ready); else pass_cnt++;
    total_cnt++; if (id_instr !== 16'h0000) $display("FAIL reset_id_instr got %h exp 0000", id_instr); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd0) $display("FAIL reset_stall_count got %0d exp 0", stall_count); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [15:0] vec [3];
    vec[0] = 16'h1234; vec[1] = 16'h5678; vec[2] = 16'h9ABC;
    id_ready = 1'b1; ex_valid = 1'b0; if_valid = 1'b1; if_instr = vec[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      if_instr = (i < 2) ? vec[i+1] : 16'h0000;
      if_valid = (i < 2);
      #1;
      total_cnt++; if (id_instr !== vec[i]) $display("FAIL stream_instr_%0d got %h exp %h", i, id_instr, vec[i]); else pass_cnt++;
      total_cnt++; if (id_valid !== 1'b1) $display("FAIL stream_valid_%0d got %b exp 1", i, id_valid); else pass_cnt++;
    end
    tick();
    #1;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL stream_drain_valid got %b exp 0", id_valid); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'd0) $display("FAIL stream_no_stall got %0d exp 0", stall_count); else pass_cnt++;
  endtask

  task automatic test_load_use();
    logic [15:0] sc0;
    int          n;
    bit          done;
    if_valid = 1'b1; if_instr = 16'h8345; id_ready = 1'b1; ex_valid = 1'b0;
    tick();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'h4;
    #1;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL lu_detect_valid got %b exp 0", id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL lu_detect_ready got %b exp 0", if_ready); else pass_cnt++;
    sc0 = stall_count;
    tick();
    // The load has moved on; count the bubble cycles spent in the hazard state
    ex_valid = 1'b0;
    n = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (id_valid === 1'b0 && if_ready === 1'b0) begin
        n++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    total_cnt++; if (n !== 1) $display("FAIL lu_bubble_cycles got %0d exp 1", n); else pass_cnt++;
    total_cnt++; if (stall_count !== sc0 + 16'd1) $display("FAIL lu_stall_count got %0d exp %0d", stall_count, sc0 + 16'd1); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL lu_resume_valid got %b exp 1", id_valid); else pass_cnt++;
    total_cnt++; if (id_instr !== 16'h8345) $display("FAIL lu_held_instr got %h exp 8345", id_instr); else pass_cnt++;
    tick();
  endtask

  task automatic test_no_false_hazard();
    logic [15:0] sc0;
    sc0 = stall_count;
    if_valid = 1'b1; if_instr = 16'h7FFF; id_ready = 1'b1; ex_valid = 1'b0;
    tick();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'hF;
    #1;
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL nofalse_7fff_valid got %b exp 1", id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL nofalse_7fff_ready got %b exp 1", if_ready); else pass_cnt++;
    if_valid = 1'b1; if_instr = 16'h1F30;
    tick();
    if_valid = 1'b0; ex_rd = 4'h3;
    #1;
    // 0xxx opcode reads only rA=F, so ex_rd=3 in the rB slot is harmless
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL nofalse_rb_valid got %b exp 1", id_valid); else pass_cnt++;
    ex_rd = 4'hF;
    #1;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL hazard_ra_valid got %b exp 0", id_valid); else pass_cnt++;
    ex_valid = 1'b0;
    #1;
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL nonload_valid got %b exp 1", id_valid); else pass_cnt++;
    tick();
    total_cnt++; if (stall_count !== sc0) $display("FAIL nofalse_stall got %0d exp %0d", stall_count, sc0); else pass_cnt++;
  endtask

  task automatic test_backpressure_flush();
    id_ready = 1'b0; ex_valid = 1'b0; if_valid = 1'b1; if_instr = 16'h2A10;
    tick();
    if_instr = 16'h1111;
    #1;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL bp_if_ready got %b exp 0", if_ready); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b1) $display("FAIL bp_id_valid got %b exp 1", id_valid); else pass_cnt++;
    tick();
    total_cnt++; if (id_instr !== 16'h2A10) $display("FAIL bp_held got %h exp 2a10", id_instr); else pass_cnt++;
    flush = 1'b1;
    #1;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL flush_if_ready got %b exp 0", if_ready); else pass_cnt++;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    total_cnt++; if (id_instr !== 16'h0000) $display("FAIL flush_instr got %h exp 0000", id_instr); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL flush_empty_ready got %b exp 1", if_ready); else pass_cnt++;
  endtask

  task automatic test_saturation();
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_valid = 1'b0; id_ready = 1'b1;
    tick();
    rst = 1'b0;
    if_valid = 1'b1; if_instr = 16'h8345;
    tick();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'h3;
    tick();
    // Now in the hazard state with one more bubble pending; flush here
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total_cnt++; if (s_stall_count !== 4'd0) $display("FAIL sat_flush_nocount got %0d exp 0", s_stall_count); else pass_cnt++;
    total_cnt++; if (s_id_instr !== 16'h0000) $display("FAIL sat_flush_instr got %h exp 0000", s_id_instr); else pass_cnt++;
    total_cnt++; if (s_if_ready !== 1'b1) $display("FAIL sat_flush_empty got %b exp 1", s_if_ready); else pass_cnt++;
    if_valid = 1'b1;
    tick();
    if_valid = 1'b0;
    // Each hazard round costs 3 cycles and adds STALL_CYCLES=2 to the count
    for (int i = 0; i < 6; i++) tick();
    total_cnt++; if (s_stall_count !== 4'd4) $display("FAIL sat_partial got %0d exp 4", s_stall_count); else pass_cnt++;
    for (int i = 0; i < 40; i++) tick();
    total_cnt++; if (s_stall_count !== 4'hF) $display("FAIL sat_full got %0d exp 15", s_stall_count); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (s_stall_count !== 4'hF) $display("FAIL sat_nowrap got %0d exp 15", s_stall_count); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    #1;
    total_cnt++; if (s_stall_count !== 4'd0) $display("FAIL sat_rst_clear got %0d exp 0", s_stall_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_load_use();
    test_no_false_hazard();
    test_backpressure_flush();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
